// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding fetches and buffers
// {pc, inst} pairs for decode. Define IFU_MISALIGN_CHK_EN to trap misaligned redirect targets.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_excp
);

   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
`ifdef IFU_MISALIGN_CHK_EN
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
`else
      ST_FLUSH = 2'd2
`endif
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       pc;
   logic [31:0]       pc_nxt;
   logic [31:0]       tag;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [31:0]       fifo_pc   [FIFO_DEPTH];
   logic [31:0]       fifo_inst [FIFO_DEPTH];
   logic              outstanding;
   logic [CNT_W:0]    in_use;
   logic              req_fire;
   logic              resp_in_wait;
   logic              stale_after_redirect;
   logic              push;
   logic              pop;
   logic [31:0]       redirect_tgt;
   logic [31:0]       push_pc;
   logic [31:0]       push_inst;

`ifdef IFU_MISALIGN_CHK_EN
   logic              misalign;
   logic              mark_pending;
   logic              push_mark;
   logic              flush_to_halt;
   logic              flush_to_halt_nxt;
   logic              fifo_excp [FIFO_DEPTH];

   assign misalign     = |redirect_pc[1:0];
   assign redirect_tgt = redirect_pc;
   // The exception marker is queued the cycle after the redirect that produced it
   assign push_mark    = mark_pending & ~redirect_valid;
   assign push         = resp_in_wait | push_mark;
   assign push_pc      = push_mark ? pc : tag;
   assign push_inst    = push_mark ? NOP_INST : imem_resp_data;
`else
   logic              unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];
   assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
   assign push           = resp_in_wait;
   assign push_pc        = tag;
   assign push_inst      = imem_resp_data;
`endif

   assign outstanding          = (state == ST_WAIT) || (state == ST_FLUSH);
   assign in_use               = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
   assign imem_req_valid       = (state == ST_REQ) && (in_use < DEPTH_V);
   assign imem_req_addr        = pc;
   assign req_fire             = imem_req_valid & imem_req_ready;
   assign resp_in_wait         = (state == ST_WAIT) & imem_resp_valid & ~redirect_valid;
   assign stale_after_redirect = outstanding & ~imem_resp_valid;
   assign out_valid            = (count != '0);
   assign pop                  = out_valid & out_ready & ~redirect_valid;

   always_comb begin
      state_nxt = state;
`ifdef IFU_MISALIGN_CHK_EN
      flush_to_halt_nxt = flush_to_halt;
`endif
      if (redirect_valid) begin
         // A response arriving with the redirect retires the outstanding slot, so no flush is needed
         if (stale_after_redirect) begin
            state_nxt = ST_FLUSH;
`ifdef IFU_MISALIGN_CHK_EN
         end else if (misalign) begin
            state_nxt = ST_HALT;
`endif
         end else begin
            state_nxt = ST_REQ;
         end
`ifdef IFU_MISALIGN_CHK_EN
         flush_to_halt_nxt = stale_after_redirect & misalign;
`endif
      end else begin
         case (state)
            ST_REQ:   if (req_fire) state_nxt = ST_WAIT;
            ST_WAIT:  if (imem_resp_valid) state_nxt = ST_REQ;
`ifdef IFU_MISALIGN_CHK_EN
            ST_FLUSH: if (imem_resp_valid) state_nxt = flush_to_halt ? ST_HALT : ST_REQ;
            ST_HALT:  state_nxt = ST_HALT;
`else
            ST_FLUSH: if (imem_resp_valid) state_nxt = ST_REQ;
`endif
            default:  state_nxt = ST_REQ;
         endcase
      end
   end

   always_comb begin
      pc_nxt = pc;
      if (redirect_valid) begin
         pc_nxt = redirect_tgt;
      end else if (req_fire) begin
         pc_nxt = pc + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_REQ;
         pc    <= RESET_PC;
         tag   <= '0;
`ifdef IFU_MISALIGN_CHK_EN
         mark_pending  <= 1'b0;
         flush_to_halt <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (req_fire) tag <= pc;
`ifdef IFU_MISALIGN_CHK_EN
         mark_pending  <= redirect_valid & misalign;
         flush_to_halt <= flush_to_halt_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= push_pc;
         fifo_inst[wr_ptr] <= push_inst;
`ifdef IFU_MISALIGN_CHK_EN
         fifo_excp[wr_ptr] <= push_mark;
`endif
      end
   end

   // Head fields read as zero while the buffer is empty
   assign out_pc   = out_valid ? fifo_pc[rd_ptr]   : '0;
   assign out_inst = out_valid ? fifo_inst[rd_ptr] : '0;
`ifdef IFU_MISALIGN_CHK_EN
   assign out_excp = out_valid & fifo_excp[rd_ptr];
`else
   assign out_excp = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-based reference model checked every cycle, a latency-randomised
// memory responder, directed scenarios with literal expectations, then a random phase.
module tb_ifu_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_excp;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .out_excp        (out_excp)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: abstract fetch state plus a queue standing in for the buffer
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
   } entry_t;

   entry_t      q[$];
   logic [31:0] m_pc;
   logic [31:0] m_tag;
   bit          m_busy;
   bit          m_stale;
   bit          m_halt;
   bit          m_halt_after;
   bit          m_mark;

   logic [31:0] fired[$];
   logic [31:0] seen_pc[$];
   logic [31:0] seen_inst[$];
   logic        seen_excp[$];

   function automatic bit model_can_req();
      return !m_busy && !m_halt && (q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      q.delete();
      m_pc = RPC; m_tag = '0;
      m_busy = 0; m_stale = 0; m_halt = 0; m_halt_after = 0; m_mark = 0;
   endtask

   task automatic model_step();
      entry_t e;
      bit     fire;
      bit     busy_after;
      if (redirect_valid) begin
         q.delete();
         busy_after = m_busy && !imem_resp_valid;
         m_busy  = busy_after;
         m_stale = busy_after;
`ifdef IFU_MISALIGN_CHK_EN
         m_pc         = redirect_pc;
         m_mark       = (redirect_pc[1:0] != 2'b00);
         m_halt       = m_mark && !busy_after;
         m_halt_after = m_mark && busy_after;
`else
         m_pc         = redirect_pc & ~32'h3;
         m_mark       = 0;
         m_halt       = 0;
         m_halt_after = 0;
`endif
      end else begin
         fire = model_can_req() && imem_req_ready;
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (m_mark) begin
            e.pc = m_pc; e.inst = 32'h0000_0013; e.excp = 1'b1;
            q.push_back(e);
            m_mark = 0;
         end
         if (fire) begin
            m_tag  = m_pc;
            m_pc   = m_pc + 32'd4;
            m_busy = 1;
            m_stale = 0;
         end else if (m_busy && imem_resp_valid) begin
            if (!m_stale) begin
               e.pc = m_tag; e.inst = imem_resp_data; e.excp = 1'b0;
               q.push_back(e);
            end else if (m_halt_after) begin
               m_halt = 1;
               m_halt_after = 0;
            end
            m_busy  = 0;
            m_stale = 0;
         end
      end
   endtask

   // Single compare process: outputs vs model every non-reset cycle, then advance the model
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
      end else begin
         check("req_valid", imem_req_valid, model_can_req());
         if (model_can_req()) check("req_addr", imem_req_addr, m_pc);
         check("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_inst", out_inst, q[0].inst);
            check("out_excp", out_excp, q[0].excp);
         end
         if (out_valid && out_ready && !redirect_valid) begin
            seen_pc.push_back(out_pc);
            seen_inst.push_back(out_inst);
            seen_excp.push_back(out_excp);
         end
         if (imem_req_valid && imem_req_ready) fired.push_back(imem_req_addr);
         model_step();
      end
   end

   // Memory responder and stimulus
   int          lat_cfg;
   bit          rand_mode;
   bit          ready_en;
   logic [31:0] salt;
   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_data;

   task automatic tick();
      bit          f;
      logic [31:0] a;
      @(negedge clk);
      f = imem_req_valid && imem_req_ready;
      a = imem_req_addr;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      if (imem_resp_valid) mem_pend = 0;
      if (rst) begin
         mem_pend = 0;
      end else if (f) begin
         mem_pend = 1;
         mem_cnt  = (lat_cfg < 0) ? int'($urandom_range(2, 0)) : lat_cfg;
         mem_data = a ^ 32'hDEAD_BEEF ^ salt;
      end
      if (mem_pend && mem_cnt == 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_data;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
         if (mem_pend) mem_cnt--;
      end
      if (rand_mode) begin
         ready_en  = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(2, 0) != 0);
      end
      imem_req_ready = ready_en && !mem_pend;
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      imem_req_ready = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      rand_mode = 0; ready_en = 1; out_ready = 1; lat_cfg = 0; salt = '0;
      repeat (3) tick();
      rst = 1'b0;
      fired.delete(); seen_pc.delete(); seen_inst.delete(); seen_excp.delete();
   endtask

   task automatic run_until_fired(input int n, input int budget, input string name);
      for (int i = 0; i < budget && fired.size() < n; i++) tick();
      check(name, fired.size(), n);
   endtask

   task automatic run_until_seen(input int n, input int budget, input string name);
      for (int i = 0; i < budget && seen_pc.size() < n; i++) tick();
      check(name, seen_pc.size(), n);
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(3, 0))
         0:       t = 32'hFFFF_FFF8;
         1:       t = RPC;
         default: begin
            t = $urandom;
            if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
         end
      endcase
      return t;
   endfunction

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      out_ready = 1'b1; mem_pend = 0; mem_cnt = 0; mem_data = '0;
      reset_dut();

      check("rst_req_valid", imem_req_valid, 1);
      check("rst_req_addr", imem_req_addr, 32'h8000_0000);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_inst", out_inst, 0);
      check("rst_out_excp", out_excp, 0);

      // Straight-line fetch, data returned unchanged
      run_until_seen(3, 30, "seq_wait");
      check("seq_pc0", seen_pc[0], 32'h8000_0000);
      check("seq_pc1", seen_pc[1], 32'h8000_0004);
      check("seq_pc2", seen_pc[2], 32'h8000_0008);
      check("seq_inst0", seen_inst[0], 32'h5EAD_BEEF);
      check("seq_inst1", seen_inst[1], 32'h5EAD_BEEB);
      check("seq_inst2", seen_inst[2], 32'h5EAD_BEE7);

      // Back-pressure: exactly DEPTH requests, then resume at the next PC
      reset_dut();
      out_ready = 1'b0;
      repeat (20) tick();
      check("stall_fires", fired.size(), 2);
      check("stall_req_valid", imem_req_valid, 0);
      out_ready = 1'b1;
      run_until_fired(3, 20, "resume_wait");
      check("resume_addr", fired[2], 32'h8000_0008);

      // Redirect while waiting, stale response the next cycle
      reset_dut();
      lat_cfg = 1;
      run_until_fired(1, 10, "flush_fire_wait");
      do_redirect(32'h8000_1000);
      lat_cfg = 0;
      tick();
      check("flush_out_valid", out_valid, 0);
      run_until_seen(1, 20, "flush_seen_wait");
      check("flush_first_pc", seen_pc[0], 32'h8000_1000);
      check("flush_first_inst", seen_inst[0], 32'h5EAD_AEEF);
      check("flush_fire1", fired[1], 32'h8000_1000);

      // Redirect in the same cycle as a response
      reset_dut();
      run_until_fired(1, 10, "same_fire_wait");
      check("same_resp_now", imem_resp_valid, 1);
      do_redirect(32'h8000_2000);
      tick();
      check("same_req_valid", imem_req_valid, 1);
      check("same_req_addr", imem_req_addr, 32'h8000_2000);
      run_until_seen(1, 20, "same_seen_wait");
      check("same_first_pc", seen_pc[0], 32'h8000_2000);

      // PC wrap at the top of the address space
      reset_dut();
      do_redirect(32'hFFFF_FFFC);
      tick();
      run_until_fired(2, 20, "wrap_wait");
      check("wrap_fire0", fired[0], 32'hFFFF_FFFC);
      check("wrap_fire1", fired[1], 32'h0000_0000);

`ifdef IFU_MISALIGN_CHK_EN
      reset_dut();
      do_redirect(32'h8000_0002);
      tick();
      run_until_seen(1, 10, "mis_seen_wait");
      check("mis_pc", seen_pc[0], 32'h8000_0002);
      check("mis_inst", seen_inst[0], 32'h0000_0013);
      check("mis_excp", seen_excp[0], 1);
      repeat (10) tick();
      check("mis_no_fires", fired.size(), 0);
      check("mis_halt_req", imem_req_valid, 0);
      do_redirect(32'h8000_0000);
      tick();
      run_until_fired(1, 10, "mis_resume_wait");
      check("mis_resume_addr", fired[0], 32'h8000_0000);
`endif

      // Random traffic against the model
      reset_dut();
      rand_mode = 1;
      lat_cfg   = -1;
      salt      = $urandom;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15, 0) == 0 && !(m_busy && m_stale && imem_resp_valid))
            do_redirect(pick_target());
         tick();
      end
      rand_mode = 0;
      check("random_progress", (seen_pc.size() > 100), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit sitting directly upstream of the instruction memory and decode. Owns the architectural fetch PC, issues one-outstanding-request fetches over a valid/ready request channel, and collects responses. Buffers fetched words with their PCs in a small FIFO that feeds decode. Supports redirects from execute/trap logic, with discard of stale in-flight responses.

## Interface
- `RESET_PC`, 32'h8000_0000, fetch PC loaded by reset
- `FIFO_DEPTH`, 2, output buffer entries; power of two, ≥2
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `redirect_valid` in 1: load new fetch PC, flush buffer
- `redirect_pc` in 32: redirect target
- `imem_req_valid` out 1: fetch request valid
- `imem_req_addr` out 32: fetch address
- `imem_req_ready` in 1: memory accepts request
- `imem_resp_valid` in 1: response word valid, one per accepted request
- `imem_resp_data` in 32: fetched instruction
- `out_valid` out 1: buffered instruction available to decode
- `out_ready` in 1: decode consumes head entry
- `out_pc` out 32: PC of head entry
- `out_inst` out 32: instruction of head entry
- `out_excp` out 1: head entry is a fetch-misalign exception marker

## Operation
- States: REQ (may issue), WAIT (one request outstanding), FLUSH (outstanding response is stale), HALT (misalign marker queued, no fetching; only with macro).
- Credit rule: `imem_req_valid` = state REQ and (fifo_count + outstanding) < FIFO_DEPTH. `imem_req_addr` = pc.
- Request fire (valid & ready): pc ← pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), REQ→WAIT. Latched address pushed to PC tag register.
- WAIT + `imem_resp_valid`: push {tag, data, excp=0} into FIFO, →REQ. Responses in REQ/HALT are ignored.
- FLUSH + `imem_resp_valid`: drop response, →REQ.
- Pop on `out_valid & out_ready`. Push and pop in the same cycle are both allowed.
- Redirect has priority over everything in its cycle:
  - FIFO cleared; same-cycle pop/push discarded; pc ← redirect_pc.
  - WAIT without same-cycle response → FLUSH. WAIT with same-cycle response → REQ, response dropped.
  - FLUSH stays FLUSH. REQ/HALT → REQ.
  - An unaccepted request is silently retargeted. Request address may change while valid only on redirect.
- `imem_req_valid` and addr are held stable until fire, otherwise.

## Timing
- Reset values: state REQ, pc=RESET_PC, FIFO empty, `imem_req_valid`=1 (addr RESET_PC) in first cycle after reset deasserts, `out_valid`=0, `out_pc`=0, `out_inst`=0, `out_excp`=0.
- Response no earlier than cycle after request fire. FIFO registered: response at cycle N → `out_valid` at N+1.
- Best-case throughput: one instruction per 2 cycles (req, resp) with single outstanding request.
- Redirect at cycle N: `out_valid`=0 at N+1; new request at N+1 if not FLUSH.
- Memory is assumed reset with the fetch unit; no response survives reset.

## Configuration
- `IFU_MISALIGN_CHK_EN` defined:
  - A redirect with redirect_pc[1:0]≠0 issues no request.
  - The FIFO is cleared and one entry {pc=redirect_pc, inst=32'h0000_0013, excp=1} is enqueued next cycle.
  - Then → HALT until next redirect. If FLUSH was pending, the stale response is still dropped before HALT.
- Undefined: redirect_pc[1:0] forced to 0, `out_excp` tied 0, HALT state absent.

## Test plan
- Reset, `imem_req_ready`=1, response 1 cycle after each fire, `out_ready`=1 → out_pc sequence 8000_0000, 8000_0004, 8000_0008; data returned unchanged.
- `out_ready`=0 with DEPTH=2 → exactly 2 requests issued, then `imem_req_valid`=0. Raise `out_ready` → fetching resumes at 8000_0008.
- Redirect to 8000_1000 while WAIT; stale response next cycle → stale response not output; next out_pc=8000_1000.
- Redirect in the same cycle as a response → that response dropped; next request addr=redirect_pc one cycle later.
- pc=FFFF_FFFC fetched → next request addr 0000_0000.
- With macro, redirect to 8000_0002 → one entry out_excp=1, out_inst=0000_0013, no further requests until redirect to 8000_0000.
